// File: rtl/reg_bus_initiator_pkg.sv
// Shared types and constants for the vicii CPU-side register bus.
// FSM encodings, bus widths, register indices and the latched command bundle.
package reg_bus_initiator_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMED  = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic [ADDR_W-1:0] REG_CTRL1    = 6'h11;
  localparam logic [ADDR_W-1:0] REG_RASTER   = 6'h12;
  localparam logic [ADDR_W-1:0] REG_MEM_PTRS = 6'h18;
  localparam logic [ADDR_W-1:0] REG_IRQ      = 6'h19;
  localparam logic [ADDR_W-1:0] REG_BORDER   = 6'h20;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } reg_cmd_t;

  function automatic logic is_busy(input logic [2:0] s);
    return (s == S_ARMED) || (s == S_SETUP) || (s == S_ACTIVE);
  endfunction

endpackage

// File: rtl/reg_bus_initiator_phi_edge_detect.sv
// Registers the phi level and produces one-cycle rise/fall strobes.
// Ports: clk_dot4x, clk_phi in; rise, fall out (combinational strobes).
module reg_bus_initiator_phi_edge_detect (
  input  logic clk_dot4x,
  input  logic clk_phi,
  output logic rise,
  output logic fall
);

  logic phi_q;

  // phi_q tracks phi through reset too, so release never
  // fabricates an edge from a stale history bit.
  always_ff @(posedge clk_dot4x) begin
    phi_q <= clk_phi;
  end

  assign rise = clk_phi & ~phi_q;
  assign fall = ~clk_phi & phi_q;

endmodule

// File: rtl/reg_bus_initiator.sv
// Replays 6510-style register accesses into vicii, aligned to phi2 high.
// Ports: clk_dot4x/rst_n, clk_phi/aec, cmd_* valid/ready in, rsp_* out,
// ce_n/rw/ado/dbo/db_oe bus out, dbi read data in.
// Optional: define REG_BUS_TIMEOUT_EN for the stalled-phi abort (rsp_err).
module reg_bus_initiator
  import reg_bus_initiator_pkg::*;
#(
  parameter int SETUP_CYC = 2
`ifdef REG_BUS_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 80
`endif
) (
  input  logic              clk_dot4x,
  input  logic              rst_n,
  input  logic              clk_phi,
  input  logic              aec,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ce_n,
  output logic              rw,
  output logic [ADDR_W-1:0] ado,
  output logic [DATA_W-1:0] dbo,
  output logic              db_oe,
  input  logic [DATA_W-1:0] dbi
);

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);

  logic              rise;
  logic              fall;
  logic [2:0]        state;
  reg_cmd_t          cmd;
  logic [7:0]        cnt;
  logic [DATA_W-1:0] rd_shadow;

  reg_bus_initiator_phi_edge_detect u_edge (
    .clk_dot4x (clk_dot4x),
    .clk_phi   (clk_phi),
    .rise      (rise),
    .fall      (fall)
  );

`ifdef REG_BUS_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] tcnt;
  logic        timeout;
  logic        err_q;

  assign timeout = is_busy(state) && !rise && !fall
                   && (tcnt == TO_LAST);
  assign rsp_err = err_q;

  always_ff @(posedge clk_dot4x) begin
    if (!rst_n) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if (rise || fall || !is_busy(state) || timeout)
        tcnt <= '0;
      else
        tcnt <= tcnt + 16'd1;
      if (timeout)
        err_q <= 1'b1;
      else if (state == S_ACTIVE && fall)
        err_q <= 1'b0;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk_dot4x) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cmd       <= '0;
      cnt       <= '0;
      rd_shadow <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      ce_n      <= 1'b1;
      rw        <= 1'b1;
      ado       <= '0;
      dbo       <= '0;
      db_oe     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_ready && cmd_valid) begin
            cmd       <= '{cmd_rw, cmd_addr, cmd_wdata};
            cmd_ready <= 1'b0;
            state     <= S_ARMED;
          end
        end
        S_ARMED: begin
          // aec low on this rise: the VIC owns phi2, try the next one
          if (rise && aec) begin
            cnt   <= '0;
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            ce_n  <= 1'b0;
            rw    <= cmd.rw;
            ado   <= cmd.addr;
            state <= S_ACTIVE;
            if (!cmd.rw) begin
              dbo   <= cmd.wdata;
              db_oe <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_ACTIVE: begin
          // dbi on the fall cycle may already be invalid, so the
          // shadow keeps the last sample taken while phi was high
          if (fall) begin
            ce_n      <= 1'b1;
            rw        <= 1'b1;
            db_oe     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= cmd.rw ? rd_shadow : '0;
            state     <= S_RESP;
          end else begin
            rd_shadow <= dbi;
          end
        end
        S_RESP: begin
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
`ifdef REG_BUS_TIMEOUT_EN
      if (timeout) begin
        ce_n      <= 1'b1;
        rw        <= 1'b1;
        db_oe     <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_rdata <= '0;
        state     <= S_RESP;
      end
`endif
    end
  end

endmodule
